// File: rtl/seg7_time_display.sv
// Converts an 8-bit value to BCD with a double-dabble engine and scans three muxed 7-seg digits.
// Define SEG7_LZB_EN to blank leading zeros on the hundreds and tens digits.
module seg7_time_display #(
   parameter int REFRESH_DIV  = 50000,
   parameter int COMMON_ANODE = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  value,
   output logic        busy,
   output logic [11:0] bcd,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [2:0]  an
);
   localparam int         CW      = $clog2(REFRESH_DIV);
   localparam logic       INV     = (COMMON_ANODE != 0);
   localparam logic [6:0] SEG_OFF = {7{INV}};
   localparam logic [2:0] AN_OFF  = {3{INV}};

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t      state;
   logic [7:0]  last;
   logic [19:0] sr;
   logic [2:0]  iter;
   logic [19:0] sr_adj;

   // Add-3 correction on each BCD nibble before the shift.
   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < 3; i++) begin
         if (sr[8+4*i +: 4] >= 4'd5)
            sr_adj[8+4*i +: 4] = sr[8+4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         last  <= 8'd0;
         sr    <= 20'd0;
         iter  <= 3'd0;
         bcd   <= 12'd0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (value != last) begin
                  last  <= value;
                  sr    <= {12'd0, value};
                  iter  <= 3'd0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sr   <= {sr_adj[18:0], 1'b0};
               iter <= iter + 3'd1;
               if (iter == 3'd7)
                  state <= COMMIT;
            end
            COMMIT: begin
               bcd   <= sr[19:8];
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [CW-1:0] cnt;
   logic [1:0]    digit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         digit <= 2'd0;
      end else if (cnt == CW'(REFRESH_DIV - 1)) begin
         cnt   <= '0;
         digit <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   logic [3:0] nib;
   logic       blank;
   logic [6:0] glyph;
   logic [2:0] an_hi;

   always_comb begin
      case (digit)
         2'd0:    nib = bcd[3:0];
         2'd1:    nib = bcd[7:4];
         default: nib = bcd[11:8];
      endcase
      blank = 1'b0;
`ifdef SEG7_LZB_EN
      if (digit == 2'd2)
         blank = (bcd[11:8] == 4'd0);
      else if (digit == 2'd1)
         blank = (bcd[11:4] == 8'd0);
`endif
      case (nib)
         4'd0:    glyph = 7'h3F;
         4'd1:    glyph = 7'h06;
         4'd2:    glyph = 7'h5B;
         4'd3:    glyph = 7'h4F;
         4'd4:    glyph = 7'h66;
         4'd5:    glyph = 7'h6D;
         4'd6:    glyph = 7'h7D;
         4'd7:    glyph = 7'h07;
         4'd8:    glyph = 7'h7F;
         4'd9:    glyph = 7'h6F;
         default: glyph = 7'h00;
      endcase
      an_hi = 3'b001 << digit;
   end

   // Slot start (cnt == 0) is the anode-off gap that hides segment transitions.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an  <= AN_OFF;
         seg <= SEG_OFF;
         dp  <= INV;
      end else begin
         dp <= INV;
         if (cnt == '0) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
         end else begin
            an  <= an_hi ^ AN_OFF;
            seg <= blank ? SEG_OFF : (glyph ^ SEG_OFF);
         end
      end
   end

endmodule

// File: tb/tb_seg7_time_display.sv
// Scoreboard bench for seg7_time_display (REFRESH_DIV=4, common anode).
module tb_seg7_time_display;
   logic        clk;
   logic        reset;
   logic [7:0]  value;
   logic        busy;
   logic [11:0] bcd;
   logic [6:0]  seg;
   logic        dp;
   logic [2:0]  an;

   int checks = 0;
   int errors = 0;
   logic [11:0] exp_q[$];

   seg7_time_display #(.REFRESH_DIV(4), .COMMON_ANODE(1)) dut (
      .clk(clk), .reset(reset), .value(value), .busy(busy),
      .bcd(bcd), .seg(seg), .dp(dp), .an(an)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every commit (busy falling outside reset) pops one expected result.
   initial begin : monitor
      logic prev;
      int   len;
      logic [11:0] e;
      prev = 1'b0;
      len  = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prev = 1'b0;
            len  = 0;
         end else begin
            if (busy) begin
               len++;
            end else if (prev) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_commit actual=%0h required=none", bcd);
               end else begin
                  e = exp_q.pop_front();
                  chk("commit_bcd", bcd, e);
                  chk("busy_len", len, 9);
               end
               len = 0;
            end
            prev = busy;
         end
      end
   end

   task automatic wait_idle(output int cyc);
      bit done;
      cyc  = 0;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk); #1;
         cyc++;
         if (!busy && exp_q.size() == 0) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
   endtask

   // Expected glyphs are active-high; the DUT drives active-low.
   task automatic check_scan(input logic [6:0] eh, input logic [6:0] et, input logic [6:0] eu);
      int gaps, lu, lt, lh;
      logic [6:0] g;
      gaps = 0; lu = 0; lt = 0; lh = 0;
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk); #1;
         g = ~seg;
         case (an)
            3'b111: gaps++;
            3'b110: begin lu++; chk("seg_units", g, eu); end
            3'b101: begin lt++; chk("seg_tens", g, et); end
            3'b011: begin lh++; chk("seg_hundreds", g, eh); end
            default: chk("an_onehot", an, 3'b111);
         endcase
         chk("dp_off", dp, 1);
      end
      chk("gap_count", gaps, 3);
      chk("lit_units", lu, 3);
      chk("lit_tens", lt, 3);
      chk("lit_hundreds", lh, 3);
   endtask

   task automatic convert(input logic [7:0] v, input logic [11:0] e);
      int cyc;
      exp_q.push_back(e);
      value = v;
      wait_idle(cyc);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cyc;
      reset = 1'b0;
      value = 8'd99;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_an", an, 3'b111);
      chk("reset_seg", seg, 7'h7F);
      chk("reset_dp", dp, 1);
      chk("reset_busy", busy, 0);
      chk("reset_bcd", bcd, 12'h000);

      exp_q.push_back(12'h099);
      reset = 1'b1;
      @(negedge clk); #1;
      chk("busy_first_edge", busy, 1);
      wait_idle(cyc);
`ifdef SEG7_LZB_EN
      check_scan(7'h00, 7'h6F, 7'h6F);
`else
      check_scan(7'h3F, 7'h6F, 7'h6F);
`endif

      convert(8'd173, 12'h173);
      check_scan(7'h06, 7'h07, 7'h4F);

      convert(8'd255, 12'h255);
      convert(8'd0, 12'h000);
`ifdef SEG7_LZB_EN
      check_scan(7'h00, 7'h00, 7'h3F);
`else
      check_scan(7'h3F, 7'h3F, 7'h3F);
`endif

      convert(8'd5, 12'h005);
`ifdef SEG7_LZB_EN
      check_scan(7'h00, 7'h00, 7'h6D);
`else
      check_scan(7'h3F, 7'h3F, 7'h6D);
`endif

      // Change three cycles into SHIFT: the in-flight value commits first.
      exp_q.push_back(12'h010);
      exp_q.push_back(12'h200);
      value = 8'd10;
      cyc = 0;
      repeat (4) begin
         @(negedge clk); #1;
         cyc++;
      end
      value = 8'd200;
      begin
         bit done;
         done = 0;
         for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk); #1;
            cyc++;
            if (!busy && exp_q.size() == 0) done = 1;
         end
      end
      chk("back_to_back_cycles", cyc, 20);
      chk("bcd_after_b2b", bcd, 12'h200);

      // Reset while shifting aborts without committing.
      value = 8'd77;
      repeat (4) begin
         @(negedge clk); #1;
      end
      chk("busy_before_abort", busy, 1);
      reset = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_bcd", bcd, 12'h000);
      chk("abort_an", an, 3'b111);
      chk("abort_seg", seg, 7'h7F);
      exp_q.push_back(12'h077);
      @(negedge clk); #1;
      reset = 1'b1;
      wait_idle(cyc);
      chk("reconvert_bcd", bcd, 12'h077);
`ifdef SEG7_LZB_EN
      check_scan(7'h00, 7'h07, 7'h07);
`else
      check_scan(7'h3F, 7'h07, 7'h07);
`endif

      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
